// File: rtl/cpu_datapath.sv
// 8-bit accumulator datapath: PC, IR, ACC, 16x8 register file and the ALU.
// Define DATAPATH_DEBUG_PORT_EN to add a side-effect-free RF read port (dbgAddr/dbgData).
module cpu_datapath #(
    parameter int PC_WIDTH = 8,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          imemData,
    output logic [PC_WIDTH-1:0] imemAddr,
    input  logic                loadIR,
    input  logic                incPC,
    input  logic                loadPC,
    input  logic                selPC,
    input  logic                loadAcc,
    input  logic [1:0]          selACC,
    input  logic                loadReg,
    input  logic [3:0]          aluOp,
    input  logic                halt,
    output logic [7:0]          instr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          acc,
    output logic [7:0]          regOut,
    output logic [7:0]          aluResult,
`ifdef DATAPATH_DEBUG_PORT_EN
    input  logic [3:0]          dbgAddr,
    output logic [7:0]          dbgData,
`endif
    output logic                flagZ,
    output logic                flagN
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b1011;
    localparam logic [3:0] OP_SHR = 4'b1100;

    logic [PC_WIDTH-1:0] pc_q;
    logic [7:0]          ir_q;
    logic [7:0]          acc_q;
    logic [7:0]          rf [NUM_REGS];
    logic [3:0]          operand;

    assign operand  = ir_q[3:0];
    assign regOut   = rf[operand];
    assign instr    = ir_q;
    assign pc       = pc_q;
    assign imemAddr = pc_q;
    assign acc      = acc_q;

`ifdef DATAPATH_DEBUG_PORT_EN
    assign dbgData = rf[dbgAddr];
`endif

    // Unknown or unused opcodes (X included) fall to ACC pass-through so flags stay clean.
    always_comb begin
        aluResult = acc_q;
        case (aluOp)
            OP_ADD:  aluResult = regOut + acc_q;
            OP_SUB:  aluResult = regOut - acc_q;
            OP_NOR:  aluResult = ~(regOut | acc_q);
            OP_SHL:  aluResult = {acc_q[6:0], 1'b0};
            OP_SHR:  aluResult = {1'b0, acc_q[7:1]};
            default: aluResult = acc_q;
        endcase
    end

    assign flagZ = (aluResult == 8'h00);
    assign flagN = aluResult[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            ir_q  <= 8'h00;
            acc_q <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= 8'h00;
        end else if (!halt) begin
            if (loadIR) ir_q <= imemData;

            if (loadPC)
                pc_q <= selPC ? PC_WIDTH'(regOut) : PC_WIDTH'(operand);
            else if (incPC)
                pc_q <= pc_q + 1'b1;

            if (loadAcc) begin
                case (selACC)
                    2'b00:   acc_q <= aluResult;
                    2'b10:   acc_q <= regOut;
                    2'b11:   acc_q <= {4'h0, operand};
                    default: acc_q <= acc_q;
                endcase
            end

            // Non-blocking write: RF captures the pre-edge ACC even if ACC loads on this edge.
            if (loadReg) rf[operand] <= acc_q;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath; hand-computed expectations.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       reset, loadIR, incPC, loadPC, selPC, loadAcc, loadReg, halt;
    logic [1:0] selACC;
    logic [3:0] aluOp;
    logic [7:0] imemData, imemAddr, instr, pc, acc, regOut, aluResult;
    logic       flagZ, flagN;
`ifdef DATAPATH_DEBUG_PORT_EN
    logic [3:0] dbgAddr;
    logic [7:0] dbgData;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_datapath #(.PC_WIDTH(8), .NUM_REGS(16)) dut (
        .clk(clk), .reset(reset), .imemData(imemData), .imemAddr(imemAddr),
        .loadIR(loadIR), .incPC(incPC), .loadPC(loadPC), .selPC(selPC),
        .loadAcc(loadAcc), .selACC(selACC), .loadReg(loadReg), .aluOp(aluOp),
        .halt(halt), .instr(instr), .pc(pc), .acc(acc), .regOut(regOut),
        .aluResult(aluResult),
`ifdef DATAPATH_DEBUG_PORT_EN
        .dbgAddr(dbgAddr), .dbgData(dbgData),
`endif
        .flagZ(flagZ), .flagN(flagN)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        loadIR = 0; incPC = 0; loadPC = 0; selPC = 0;
        loadAcc = 0; selACC = 2'b00; loadReg = 0; halt = 0;
    endtask

    task automatic ld_ir(input logic [7:0] v);
        imemData = v; loadIR = 1; tick(); loadIR = 0;
    endtask

    task automatic ld_acc(input logic [1:0] sel);
        selACC = sel; loadAcc = 1; tick(); loadAcc = 0;
    endtask

    task automatic alu_acc(input logic [3:0] op);
        aluOp = op; selACC = 2'b00; loadAcc = 1; tick(); loadAcc = 0;
    endtask

    task automatic st_reg();
        loadReg = 1; tick(); loadReg = 0;
    endtask

    initial begin
        idle();
        reset = 1; aluOp = 4'b0001; imemData = 8'h00;
`ifdef DATAPATH_DEBUG_PORT_EN
        dbgAddr = 4'd0;
`endif
        tick(); tick();
        reset = 0;

        // Reset state
        chk("rst_ir", instr, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_acc", acc, 8'h00);
        chk("rst_rf0", regOut, 8'h00);
        chk("rst_alu", aluResult, 8'h00);
        chk("rst_z", {7'b0, flagZ}, 8'h01);

        // Fetch edge
        imemData = 8'hD5; loadIR = 1; incPC = 1; tick(); loadIR = 0; incPC = 0;
        chk("fetch_ir", instr, 8'hD5);
        chk("fetch_pc", pc, 8'h01);
        chk("fetch_addr", imemAddr, 8'h01);

        ld_acc(2'b11);
        chk("imm_acc", acc, 8'h05);
        ld_ir(8'h53); st_reg();
        chk("rf3_wr", regOut, 8'h05);
        chk("ldir_pc_hold", pc, 8'h01);

        ld_ir(8'h13);
        aluOp = 4'b0001; #1;
        chk("add_res", aluResult, 8'h0A);
        alu_acc(4'b0001);
        chk("add_acc", acc, 8'h0A);
        chk("add_z", {7'b0, flagZ}, 8'h00);
        chk("add_n", {7'b0, flagN}, 8'h00);

        aluOp = 4'b0010; #1;
        chk("sub_res", aluResult, 8'hFB);
        chk("sub_n", {7'b0, flagN}, 8'h01);

        // RF[3]=F5 via NOR with a zero register, then NOR to zero
        ld_ir(8'h14); alu_acc(4'b0011);
        chk("nor_f5", acc, 8'hF5);
        ld_ir(8'h13); st_reg();
        ld_ir(8'h1A); ld_acc(2'b11);
        ld_ir(8'h13);
        aluOp = 4'b0011; #1;
        chk("nor_res", aluResult, 8'h00);
        chk("nor_z", {7'b0, flagZ}, 8'h01);

        // ACC=81 then shifts and pass-through
        ld_ir(8'h11); ld_acc(2'b11); st_reg();
        ld_ir(8'h18); ld_acc(2'b11);
        repeat (4) alu_acc(4'b1011);
        chk("shl_chain", acc, 8'h80);
        ld_ir(8'h11); alu_acc(4'b0001);
        chk("acc_81", acc, 8'h81);
        aluOp = 4'b1100; #1;
        chk("shr_res", aluResult, 8'h40);
        aluOp = 4'b1011; #1;
        chk("shl_res", aluResult, 8'h02);
        aluOp = 4'b0000; #1;
        chk("pass_res", aluResult, 8'h81);
        aluOp = 4'bxxxx; #1;
        chk("passx_res", aluResult, 8'h81);
        chk("passx_z", {7'b0, flagZ}, 8'h00);
        chk("passx_n", {7'b0, flagN}, 8'h01);

        // PC wrap and load priority
        ld_ir(8'h10); ld_acc(2'b11);
        ld_ir(8'h14); alu_acc(4'b0011); st_reg();
        selPC = 1; loadPC = 1; tick(); loadPC = 0;
        chk("pc_ff", pc, 8'hFF);
        incPC = 1; tick(); incPC = 0;
        chk("pc_wrap", pc, 8'h00);
        ld_ir(8'h7C);
        selPC = 0; loadPC = 1; incPC = 1; tick(); loadPC = 0; incPC = 0;
        chk("pc_ld_wins", pc, 8'h0C);

        // Build 9A in RF[A] and jump there
        ld_ir(8'h1A); ld_acc(2'b11); st_reg();
        ld_ir(8'h19); ld_acc(2'b11);
        repeat (4) alu_acc(4'b1011);
        ld_ir(8'h1A); alu_acc(4'b0001);
        chk("acc_9a", acc, 8'h9A);
        st_reg();
        selPC = 1; loadPC = 1; tick(); loadPC = 0;
        chk("pc_reg", pc, 8'h9A);
        chk("addr_reg", imemAddr, 8'h9A);

        // Halt freezes all state; combinational paths stay live
        halt = 1; imemData = 8'h55; loadIR = 1; incPC = 1; loadPC = 1; selPC = 0;
        loadAcc = 1; selACC = 2'b11; loadReg = 1; aluOp = 4'b0001;
        repeat (5) tick();
        chk("halt_pc", pc, 8'h9A);
        chk("halt_ir", instr, 8'h1A);
        chk("halt_acc", acc, 8'h9A);
        chk("halt_rf", regOut, 8'h9A);
        chk("halt_alu", aluResult, 8'h34);
        reset = 1; tick(); reset = 0;
        idle();
        chk("hrst_pc", pc, 8'h00);
        chk("hrst_ir", instr, 8'h00);
        chk("hrst_acc", acc, 8'h00);
        ld_ir(8'h1A);
        chk("hrst_rfa", regOut, 8'h00);

        // Reset beats a fetch on the same edge
        imemData = 8'h55; loadIR = 1; reset = 1; tick(); reset = 0; loadIR = 0;
        chk("rst_fetch_ir", instr, 8'h00);

        // Simultaneous ACC load and RF write
        ld_ir(8'h11); ld_acc(2'b11); st_reg();
        repeat (4) alu_acc(4'b1011);
        alu_acc(4'b0001);
        ld_ir(8'h12); alu_acc(4'b1011); st_reg(); alu_acc(4'b1100);
        chk("pre_acc", acc, 8'h11);
        chk("pre_rf2", regOut, 8'h22);
        selACC = 2'b10; loadAcc = 1; loadReg = 1; tick(); loadAcc = 0; loadReg = 0;
        chk("swap_acc", acc, 8'h22);
        chk("swap_rf2", regOut, 8'h11);
        selACC = 2'b01; loadAcc = 1; tick(); loadAcc = 0;
        chk("hold_acc", acc, 8'h22);
`ifdef DATAPATH_DEBUG_PORT_EN
        dbgAddr = 4'd2; #1;
        chk("dbg_rf2", dbgData, 8'h11);
        dbgAddr = 4'd1; #1;
        chk("dbg_rf1", dbgData, 8'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 8-bit accumulator datapath driven by the controller FSM's control strobes.
- Holds PC, IR, ACC, a 16x8 register file and the ALU.
- Drives the instruction memory address, returns `instr` to the controller, and produces the combinational Z/N flags that the controller latches.
- Sits directly downstream of the controller; it is the only consumer of the controller's control strobes.

Parameters:
- PC_WIDTH, 8, width of PC and of the instruction memory address.
- NUM_REGS, 16, register file depth; fixed at 16 because the operand field is 4 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imemData  in  8  instruction memory read data for address `imemAddr` (combinational ROM).
- imemAddr  out  PC_WIDTH  equals `pc`.
- loadIR  in  1  IR <= imemData.
- incPC  in  1  PC <= PC+1.
- loadPC  in  1  load PC from the source chosen by `selPC`.
- selPC  in  1  1 = regOut, 0 = zero-extended immediate.
- loadAcc  in  1  load ACC from the source chosen by `selACC`.
- selACC  in  2  00 = ALU result, 10 = regOut, 11 = zero-extended immediate, 01 = reserved.
- loadReg  in  1  RF[operand] <= ACC.
- aluOp  in  4  0001 ADD, 0010 SUB, 0011 NOR, 1011 SHL, 1100 SHR.
- halt  in  1  freeze all state.
- instr  out  8  current IR contents.
- pc  out  PC_WIDTH  current PC.
- acc  out  8  current ACC.
- regOut  out  8  RF[instr[3:0]], combinational read.
- aluResult  out  8  combinational ALU output.
- flagZ  out  1  aluResult == 0.
- flagN  out  1  aluResult[7].

Behaviour:
- Reset (synchronous, active-high) has priority over every other input. It sets pc=0, IR=8'h00 (NOP), ACC=0 and all 16 RF entries to 0. After reset, `aluResult` follows aluOp and ACC=0.
- Operand is `instr[3:0]`. It is both the RF index and the 4-bit immediate.
- IR: when loadIR=1, IR <= imemData, sampled at `imemAddr` = old pc.
- PC:
  - loadPC has priority over incPC.
  - With loadPC=1: selPC=1 loads regOut zero-extended or truncated to PC_WIDTH; selPC=0 loads {0, instr[3:0]}.
  - With loadPC=0 and incPC=1: pc <= pc+1, wrapping modulo 2^PC_WIDTH (all-ones -> 0).
- Fetch edge: loadIR and incPC asserted together on one edge gives IR=mem[old pc] and pc=old pc+1.
- ACC:
  - When loadAcc=1, ACC takes the source selected by `selACC`.
  - selACC=01 holds ACC, even with loadAcc=1.
- ALU (combinational, 8-bit, modulo 256, no carry out):
  - ADD = regOut + ACC.
  - SUB = regOut - ACC (two's complement wrap).
  - NOR = ~(regOut | ACC).
  - SHL = ACC << 1, zero fill.
  - SHR = ACC >> 1, logical, zero fill.
  - Any other aluOp, including X: result = ACC pass-through. X must never propagate to the flags.
- Register file: when loadReg=1, RF[operand] <= ACC. If loadReg and loadAcc are both asserted on one edge, RF receives the pre-edge ACC.
- Read-during-write: regOut shows the old value until the edge, then the new value.
- halt=1 suppresses every write (pc, IR, ACC, RF) regardless of the strobes. Combinational outputs stay live. Reset still works while halt=1.
- Reset mid-fetch (reset and loadIR on the same edge): reset wins and IR=0.

Optional Feature:
- Macro: DATAPATH_DEBUG_PORT_EN.
- Defined: adds `dbgAddr` (in, 4) and `dbgData` (out, 8) = RF[dbgAddr], a combinational, side-effect-free second read port for bench/probe use.
- Undefined: these ports do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then IR=8'h00, pc=0, acc=0, all RF=0. Pulse loadIR+incPC with imemData=8'hD5 -> instr=D5, pc=1.
- IR=D5: selACC=11, loadAcc -> acc=05. IR=53: loadReg -> RF[3]=05. IR=13: ADD, loadAcc -> acc=0A, flagZ=0, flagN=0.
- ACC=0A, RF[3]=05, SUB -> aluResult=FB, flagN=1. NOR with RF[3]=F5, ACC=0A -> 00, flagZ=1. ACC=81, SHR -> 40; SHL -> 02.
- pc=FF: incPC -> pc=00. loadPC+incPC with selPC=0, IR=7C -> pc=0C, load wins. selPC=1 with RF[IR[3:0]]=9A -> pc=9A.
- halt=1 with all strobes active for 5 cycles -> pc/IR/ACC/RF unchanged. Then reset -> all cleared.
- loadAcc (selACC=10) and loadReg on the same edge, ACC=11, RF[2]=22 -> ACC=22, RF[2]=11. With DATAPATH_DEBUG_PORT_EN, dbgAddr=2 -> dbgData=11.
